// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the datapath controls and counts retirements.
module mc_ctrl #(
    parameter int CNT_W  = 32,
    parameter int MEM_TO = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             bgez,
    input  logic             mem_ack,
    output logic [2:0]       state,
    output logic             pc_we,
    output logic [1:0]       npc_sel,
    output logic             ir_we,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             ext_type,
    output logic [1:0]       rd_sel,
    output logic [1:0]       grf_sel,
    output logic             reg_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        I_NOP   = 4'd0,
        I_ADDU  = 4'd1,
        I_SUBU  = 4'd2,
        I_SLT   = 4'd3,
        I_JR    = 4'd4,
        I_ORI   = 4'd5,
        I_LUI   = 4'd6,
        I_SLTIU = 4'd7,
        I_LW    = 4'd8,
        I_SW    = 4'd9,
        I_BEQ   = 4'd10,
        I_BGEZ  = 4'd11,
        I_JAL   = 4'd12,
        I_ILL   = 4'd13
    } instr_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BGEZ  = 6'h01;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Timeout fires on the MEM cycle whose non-ack edge would bring the counter to MEM_TO.
    localparam logic [7:0] TO_LAST = 8'(MEM_TO - 1);

    state_e           state_r;
    state_e           next_s;
    instr_e           instr_s;
    logic [7:0]       wait_cnt_r;
    logic [CNT_W-1:0] instr_cnt_r;

    logic       pc_we_s, ir_we_s, reg_we_s, mem_req_s, mem_we_s;
    logic       illegal_s, bus_err_s, retire_s, wait_clr_s, wait_inc_s;
    logic [1:0] npc_sel_s, alu_op_s, rd_sel_s, grf_sel_s;
    logic       alu_src_s, ext_type_s;
    logic [1:0] alu_op_d_s;
    logic       alu_src_d_s, ext_d_s;

    // Instruction class from the IR opcode/funct fields
    always_comb begin
        instr_s = I_ILL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_NOP:  instr_s = I_NOP;
                    FN_JR:   instr_s = I_JR;
                    FN_ADDU: instr_s = I_ADDU;
                    FN_SUBU: instr_s = I_SUBU;
                    FN_SLT:  instr_s = I_SLT;
                    default: instr_s = I_ILL;
                endcase
            end
            OP_BGEZ:  instr_s = I_BGEZ;
            OP_JAL:   instr_s = I_JAL;
            OP_BEQ:   instr_s = I_BEQ;
            OP_SLTIU: instr_s = I_SLTIU;
            OP_ORI:   instr_s = I_ORI;
            OP_LUI:   instr_s = I_LUI;
            OP_LW:    instr_s = I_LW;
            OP_SW:    instr_s = I_SW;
            default:  instr_s = I_ILL;
        endcase
    end

    // ALU operation, operand source and immediate extension per instruction
    always_comb begin
        alu_op_d_s  = 2'd0;
        alu_src_d_s = 1'b0;
        ext_d_s     = 1'b0;
        case (instr_s)
            I_SUBU:  alu_op_d_s = 2'd1;
            I_SLT:   alu_op_d_s = 2'd3;
            I_ORI: begin
                alu_op_d_s  = 2'd2;
                alu_src_d_s = 1'b1;
            end
            I_SLTIU: begin
                alu_op_d_s  = 2'd3;
                alu_src_d_s = 1'b1;
                ext_d_s     = 1'b1;
            end
            I_LW, I_SW: begin
                alu_src_d_s = 1'b1;
                ext_d_s     = 1'b1;
            end
            I_BEQ, I_BGEZ: begin
                alu_op_d_s = 2'd1;
                ext_d_s    = 1'b1;
            end
            default: alu_op_d_s = 2'd0;
        endcase
    end

    // Next-state and per-state control decode
    always_comb begin
        next_s     = state_r;
        pc_we_s    = 1'b0;
        npc_sel_s  = 2'd0;
        ir_we_s    = 1'b0;
        alu_op_s   = 2'd0;
        alu_src_s  = 1'b0;
        ext_type_s = 1'b0;
        rd_sel_s   = 2'd0;
        grf_sel_s  = 2'd0;
        reg_we_s   = 1'b0;
        mem_req_s  = 1'b0;
        mem_we_s   = 1'b0;
        illegal_s  = 1'b0;
        bus_err_s  = 1'b0;
        retire_s   = 1'b0;
        wait_clr_s = 1'b0;
        wait_inc_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                ir_we_s = 1'b1;
                pc_we_s = 1'b1;
                next_s  = S_DECODE;
            end
            S_DECODE: begin
                case (instr_s)
                    I_NOP: begin
                        retire_s = 1'b1;
                        next_s   = S_FETCH;
                    end
                    I_JAL: next_s = S_WB;
                    I_ILL: begin
                        illegal_s = 1'b1;
                        next_s    = S_FETCH;
                    end
                    default: next_s = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_op_s   = alu_op_d_s;
                alu_src_s  = alu_src_d_s;
                ext_type_s = ext_d_s;
                case (instr_s)
                    I_BEQ: begin
                        pc_we_s   = zero;
                        npc_sel_s = 2'd1;
                        retire_s  = 1'b1;
                        next_s    = S_FETCH;
                    end
                    I_BGEZ: begin
                        pc_we_s   = bgez;
                        npc_sel_s = 2'd1;
                        retire_s  = 1'b1;
                        next_s    = S_FETCH;
                    end
                    I_JR: begin
                        pc_we_s   = 1'b1;
                        npc_sel_s = 2'd3;
                        retire_s  = 1'b1;
                        next_s    = S_FETCH;
                    end
                    I_LW, I_SW: begin
                        wait_clr_s = 1'b1;
                        next_s     = S_MEM;
                    end
                    default: next_s = S_WB;
                endcase
            end
            S_MEM: begin
                // Address operands stay selected while the memory transfer is pending.
                alu_op_s   = alu_op_d_s;
                alu_src_s  = alu_src_d_s;
                ext_type_s = ext_d_s;
                mem_req_s  = 1'b1;
                mem_we_s   = (instr_s == I_SW);
                if (mem_ack) begin
                    if (instr_s == I_SW) begin
                        retire_s = 1'b1;
                        next_s   = S_FETCH;
                    end else begin
                        next_s = S_WB;
                    end
                end else if (wait_cnt_r == TO_LAST) begin
                    bus_err_s = 1'b1;
                    next_s    = S_FETCH;
                end else begin
                    wait_inc_s = 1'b1;
                end
            end
            S_WB: begin
                reg_we_s = 1'b1;
                retire_s = 1'b1;
                next_s   = S_FETCH;
                case (instr_s)
                    I_ORI, I_SLTIU: rd_sel_s = 2'd1;
                    I_LUI: begin
                        rd_sel_s  = 2'd1;
                        grf_sel_s = 2'd1;
                    end
                    I_LW: begin
                        rd_sel_s  = 2'd1;
                        grf_sel_s = 2'd2;
                    end
                    I_JAL: begin
                        rd_sel_s  = 2'd2;
                        grf_sel_s = 2'd3;
                        pc_we_s   = 1'b1;
                        npc_sel_s = 2'd2;
                    end
                    default: rd_sel_s = 2'd0;
                endcase
            end
            default: next_s = S_FETCH;
        endcase
    end

    // State register, MEM wait counter and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_FETCH;
            wait_cnt_r  <= 8'd0;
            instr_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_s;
            if (wait_clr_s) begin
                wait_cnt_r <= 8'd0;
            end else if (wait_inc_s) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (retire_s) begin
                instr_cnt_r <= instr_cnt_r + CNT_W'(1);
            end else begin
                instr_cnt_r <= instr_cnt_r;
            end
        end
    end

    // Enables are forced low for the whole time reset is held, even though FETCH decodes them high.
    assign state     = state_r;
    assign pc_we     = pc_we_s   & ~reset;
    assign ir_we     = ir_we_s   & ~reset;
    assign reg_we    = reg_we_s  & ~reset;
    assign mem_req   = mem_req_s & ~reset;
    assign mem_we    = mem_we_s  & ~reset;
    assign illegal   = illegal_s & ~reset;
    assign bus_err   = bus_err_s & ~reset;
    assign npc_sel   = npc_sel_s;
    assign alu_op    = alu_op_s;
    assign alu_src   = alu_src_s;
    assign ext_type  = ext_type_s;
    assign rd_sel    = rd_sel_s;
    assign grf_sel   = grf_sel_s;
    assign instr_cnt = instr_cnt_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks instruction sequences cycle by cycle and
// compares state and controls against hand-computed values.
module tb_mc_ctrl;

    localparam logic [2:0] FE = 3'd0;
    localparam logic [2:0] DE = 3'd1;
    localparam logic [2:0] EX = 3'd2;
    localparam logic [2:0] ME = 3'd3;
    localparam logic [2:0] WB = 3'd4;

    logic        clk;
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero, bgez, mem_ack;
    logic [2:0]  state;
    logic        pc_we, ir_we, alu_src, ext_type, reg_we, mem_req, mem_we, illegal, bus_err;
    logic [1:0]  npc_sel, alu_op, rd_sel, grf_sel;
    logic [31:0] instr_cnt;

    logic [5:0]  op_v, fn_v;
    logic        ack_v, z_v, bg_v;
    int          total_cnt;
    int          bad_cnt;

    mc_ctrl #(.CNT_W(32), .MEM_TO(15)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .bgez(bgez),
        .mem_ack(mem_ack), .state(state), .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we),
        .alu_op(alu_op), .alu_src(alu_src), .ext_type(ext_type), .rd_sel(rd_sel),
        .grf_sel(grf_sel), .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
        .illegal(illegal), .bus_err(bus_err), .instr_cnt(instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle, apply this cycle's inputs, then check the state.
    task automatic cyc(input logic [2:0] st, input string tag);
        @(posedge clk);
        #1;
        op      = op_v;
        funct   = fn_v;
        mem_ack = ack_v;
        zero    = z_v;
        bgez    = bg_v;
        #1;
        check_val({tag, ".st"}, 32'(state), 32'(st));
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        reset = 1'b1;
        op_v = 6'h00; fn_v = 6'h21; ack_v = 1'b0; z_v = 1'b0; bg_v = 1'b0;
        op = op_v; funct = fn_v; mem_ack = 1'b0; zero = 1'b0; bgez = 1'b0;

        #12;
        check_val("rst.st", 32'(state), 32'(FE));
        check_val("rst.en", 32'({pc_we, ir_we, reg_we, mem_req, mem_we, illegal, bus_err}), 32'd0);
        check_val("rst.cnt", instr_cnt, 32'd0);

        // addu interrupted by reset in EXEC
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("a0.fetch", 32'({pc_we, ir_we}), 32'd3);
        cyc(DE, "a0.de");
        cyc(EX, "a0.ex");
        reset = 1'b1;
        #1;
        check_val("midrst.st", 32'(state), 32'(FE));
        check_val("midrst.en", 32'({pc_we, ir_we, reg_we, mem_req, mem_we, illegal, bus_err}), 32'd0);
        check_val("midrst.cnt", instr_cnt, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rel.st", 32'(state), 32'(FE));
        check_val("rel.fetch", 32'({pc_we, ir_we, npc_sel}), 32'b1100);

        // addu, ori, lui, nop
        cyc(DE, "addu.de");
        cyc(EX, "addu.ex");
        check_val("addu.alu", 32'({alu_op, alu_src}), 32'b000);
        check_val("addu.we", 32'(reg_we), 32'd0);
        cyc(WB, "addu.wb");
        check_val("addu.wb", 32'({reg_we, rd_sel, grf_sel}), 32'b10000);
        op_v = 6'h0D; fn_v = 6'h00;
        cyc(FE, "ori.fe");
        cyc(DE, "ori.de");
        cyc(EX, "ori.ex");
        check_val("ori.alu", 32'({alu_op, alu_src, ext_type}), 32'b1010);
        cyc(WB, "ori.wb");
        check_val("ori.wb", 32'({reg_we, rd_sel, grf_sel}), 32'b10100);
        op_v = 6'h0F;
        cyc(FE, "lui.fe");
        cyc(DE, "lui.de");
        cyc(EX, "lui.ex");
        cyc(WB, "lui.wb");
        check_val("lui.wb", 32'({reg_we, rd_sel, grf_sel}), 32'b10101);
        op_v = 6'h00; fn_v = 6'h00;
        cyc(FE, "nop.fe");
        cyc(DE, "nop.de");
        check_val("nop.we", 32'({reg_we, pc_we, illegal}), 32'd0);

        // lw with three wait cycles
        op_v = 6'h23;
        cyc(FE, "lw.fe");
        check_val("seq.cnt", instr_cnt, 32'd4);
        cyc(DE, "lw.de");
        cyc(EX, "lw.ex");
        check_val("lw.alu", 32'({alu_op, alu_src, ext_type}), 32'b0011);
        for (int i = 0; i < 4; i++) begin
            ack_v = (i == 3);
            cyc(ME, "lw.me");
            check_val("lw.req", 32'({mem_req, mem_we, bus_err}), 32'b100);
        end
        ack_v = 1'b0;
        cyc(WB, "lw.wb");
        check_val("lw.wb", 32'({reg_we, rd_sel, grf_sel}), 32'b10110);

        // sw that never gets an ack
        op_v = 6'h2B;
        cyc(FE, "swto.fe");
        check_val("lw.cnt", instr_cnt, 32'd5);
        cyc(DE, "swto.de");
        cyc(EX, "swto.ex");
        for (int i = 1; i <= 15; i++) begin
            cyc(ME, "swto.me");
            check_val("swto.req", 32'({mem_req, mem_we, reg_we}), 32'b110);
            check_val("swto.berr", 32'(bus_err), 32'(i == 15));
        end
        cyc(FE, "swto.back");
        check_val("swto.cnt", instr_cnt, 32'd5);
        check_val("swto.berr0", 32'(bus_err), 32'd0);

        // sw acked on the final allowed cycle: ack beats timeout
        cyc(DE, "sw15.de");
        cyc(EX, "sw15.ex");
        for (int i = 1; i <= 15; i++) begin
            ack_v = (i == 15);
            cyc(ME, "sw15.me");
            check_val("sw15.berr", 32'(bus_err), 32'd0);
        end
        ack_v = 1'b1;
        op_v = 6'h04;
        cyc(FE, "beq0.fe");
        check_val("sw15.cnt", instr_cnt, 32'd6);

        // beq not taken (stray mem_ack ignored), beq taken, bgez taken
        cyc(DE, "beq0.de");
        cyc(EX, "beq0.ex");
        check_val("beq0.pc", 32'({pc_we, npc_sel}), 32'b001);
        ack_v = 1'b0;
        z_v = 1'b1;
        cyc(FE, "beq1.fe");
        cyc(DE, "beq1.de");
        cyc(EX, "beq1.ex");
        check_val("beq1.pc", 32'({pc_we, npc_sel}), 32'b101);
        z_v = 1'b0; bg_v = 1'b1; op_v = 6'h01;
        cyc(FE, "bgez.fe");
        check_val("beq.cnt", instr_cnt, 32'd8);
        cyc(DE, "bgez.de");
        cyc(EX, "bgez.ex");
        check_val("bgez.pc", 32'({pc_we, npc_sel}), 32'b101);
        bg_v = 1'b0;

        // jal, jr, illegal opcode
        op_v = 6'h03;
        cyc(FE, "jal.fe");
        check_val("bgez.cnt", instr_cnt, 32'd9);
        cyc(DE, "jal.de");
        cyc(WB, "jal.wb");
        check_val("jal.wb", 32'({reg_we, rd_sel, grf_sel, pc_we, npc_sel}), 32'b11011110);
        op_v = 6'h00; fn_v = 6'h08;
        cyc(FE, "jr.fe");
        cyc(DE, "jr.de");
        cyc(EX, "jr.ex");
        check_val("jr.pc", 32'({pc_we, npc_sel, reg_we}), 32'b1110);
        op_v = 6'h3F; fn_v = 6'h00;
        cyc(FE, "ill.fe");
        cyc(DE, "ill.de");
        check_val("ill.pulse", 32'(illegal), 32'd1);
        op_v = 6'h00;
        cyc(FE, "ill.back");
        check_val("ill.clr", 32'(illegal), 32'd0);
        check_val("final.cnt", instr_cnt, 32'd11);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath (IFU, GRF, ALU, DM, Ext, Shifter).
- Replaces the single-cycle decoder with a state machine: FETCH, DECODE, EXEC, MEM, WB.
- Asserts the datapath write enables and mux selects only in the state that needs them.
- Handshakes with a variable-latency data memory.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TO, 15, maximum cycles to wait in MEM for mem_ack before abort (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  6  Instr[31:26], from IR (stable after FETCH).
- funct  in  6  Instr[5:0], from IR.
- zero  in  1  ALU equality flag.
- bgez  in  1  ALU rs>=0 flag.
- mem_ack  in  1  data memory transfer complete.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- pc_we  out  1  PC register write.
- npc_sel  out  2  next-PC source: 0=PC+4, 1=branch target, 2=jump target, 3=rs.
- ir_we  out  1  instruction register write.
- alu_op  out  2  0=add, 1=sub, 2=or, 3=slt (sltiu uses 3 with unsigned compare; ALU's concern).
- alu_src  out  1  0=rt data, 1=extended immediate.
- ext_type  out  1  0=zero-extend, 1=sign-extend.
- rd_sel  out  2  GRF write address: 0=rd, 1=rt, 2=$31.
- grf_sel  out  2  GRF write data: 0=ALU, 1=Shifter (lui), 2=DM, 3=link (PC).
- reg_we  out  1  GRF write.
- mem_req  out  1  DM request.
- mem_we  out  1  DM write qualifier (valid only with mem_req).
- illegal  out  1  one-cycle pulse on undecodable instruction.
- bus_err  out  1  one-cycle pulse on MEM timeout.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- reset asynchronous, active-high; state, instr_cnt and the wait counter are registers.
- While reset is high: state=FETCH, instr_cnt=0, and every enable and pulse output (pc_we, ir_we, reg_we, mem_req, mem_we, illegal, bus_err) is 0.
- Selects are decoded combinationally from state and IR fields.
- Decode set:
  - R-type (op 00): addu 21, subu 23, slt 2A, jr 08, nop = funct 00.
  - I-type: ori 0D, lui 0F, sltiu 0B, lw 23, sw 2B, beq 04, bgez 01.
  - J-type: jal 03.
- FETCH: ir_we=1, pc_we=1, npc_sel=0. Next state DECODE.
- DECODE: no enables.
  - nop: retire, next FETCH.
  - jal: next WB.
  - illegal op/funct: illegal=1, no retire, next FETCH.
  - all others: next EXEC.
- EXEC:
  - ALU ops: alu_op and alu_src per instruction; ext_type=1 for lw/sw/beq/bgez/sltiu, 0 for ori.
  - beq: pc_we=zero, npc_sel=1; retire; next FETCH.
  - bgez: pc_we=bgez, npc_sel=1; retire; next FETCH.
  - jr: pc_we=1, npc_sel=3; retire; next FETCH.
  - lw/sw: next MEM, wait counter cleared.
  - all others: next WB.
- MEM:
  - mem_req=1 and mem_we=(op==sw) held every cycle until mem_ack is sampled high.
  - On ack: lw goes to WB; sw retires and goes to FETCH.
  - Wait counter increments each non-ack cycle. If it reaches MEM_TO without ack: bus_err pulse, no writeback, no retire, next FETCH.
  - ack in the same cycle as the counter reaching MEM_TO: ack wins.
- WB: reg_we=1, then retire, then next FETCH.
  - R-type ALU ops: rd_sel=0, grf_sel=0.
  - ori/sltiu: rd_sel=1, grf_sel=0.
  - lui: rd_sel=1, grf_sel=1.
  - lw: rd_sel=1, grf_sel=2.
  - jal: rd_sel=2, grf_sel=3, plus pc_we=1, npc_sel=2.
- Retire: instr_cnt+1 on the retiring edge; wraps modulo 2^CNT_W.
- Cycle counts:
  - nop: 2.
  - beq, bgez, jr, jal: 3.
  - R-type, ori, lui, sltiu: 4.
  - sw: 4 + wait cycles.
  - lw: 5 + wait cycles.
- Reset mid-instruction: immediate return to FETCH; no partial write completes after reset asserts.
- mem_ack outside MEM is ignored.

Test Plan:
- Reset asserted mid-EXEC of addu -> state=0, all enables 0, instr_cnt=0 immediately. After release: FETCH with pc_we=ir_we=1 on the first edge.
- Sequence addu, ori, lui, nop -> state traces 0,1,2,4 / 0,1,2,4 / 0,1,2,4 / 0,1.
  - reg_we pulses with (rd_sel, grf_sel) = (0,0), (1,0), (1,1).
  - instr_cnt=4 after 14 cycles.
- lw with mem_ack delayed 3 cycles -> mem_req high for 4 cycles, mem_we=0, then WB with rd_sel=1, grf_sel=2. Total 8 cycles.
- sw with mem_ack never asserted (MEM_TO=15) -> mem_req, mem_we high for 15 cycles, then bus_err pulse. No reg_we, instr_cnt unchanged, back in FETCH.
- beq with zero=0, then zero=1 -> pc_we=0, then pc_we=1 with npc_sel=1. bgez with bgez=1 -> same taken behaviour. Each takes 3 cycles.
- jal, then jr, then op=3F -> jal WB: reg_we=1, rd_sel=2, grf_sel=3, pc_we=1, npc_sel=2. jr EXEC: npc_sel=3. op 3F: illegal pulse in DECODE, instr_cnt +2 only.
